// File: rtl/rtc_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module : rtc_defs_pkg
// Brief  : Shared RTC bus definitions: register addresses, reader FSM state
//          encoding, segment timing default and bus-control helpers.
// Rev    : 1.0  initial release
// ============================================================================
package rtc_defs_pkg;

  localparam int unsigned T_SEG_DEF = 4;

  localparam logic [7:0] RTC_ADDR_SEC  = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR = 8'h23;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A_SU  = 4'd1;
  localparam logic [3:0] S_A_STB = 4'd2;
  localparam logic [3:0] S_A_HLD = 4'd3;
  localparam logic [3:0] S_R_SU  = 4'd4;
  localparam logic [3:0] S_R_STB = 4'd5;
  localparam logic [3:0] S_R_HLD = 4'd6;
  localparam logic [3:0] S_GAP   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  typedef struct packed {
    logic cs_n;
    logic ad_n;
    logic rd_n;
    logic oe;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_RELEASED = '{cs_n: 1'b1, ad_n: 1'b1, rd_n: 1'b1, oe: 1'b0};

  // Sweep order is seconds, minutes, hours.
  function automatic logic [7:0] reg_addr(input logic [1:0] idx,
                                          input logic [7:0] a_sec,
                                          input logic [7:0] a_min,
                                          input logic [7:0] a_hour);
    case (idx)
      2'd0:    reg_addr = a_sec;
      2'd1:    reg_addr = a_min;
      default: reg_addr = a_hour;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_time_reader_seg.sv
`default_nettype none
// ============================================================================
// Module : rtc_bus_seg_timer
// Brief  : Bus segment down-counter; seg_done marks the last cycle of a segment.
// Rev    : 1.0  initial release
// ============================================================================
module rtc_bus_seg_timer
  import rtc_defs_pkg::*;
#(
  parameter int unsigned T_SEG = T_SEG_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic seg_done
);

  localparam logic [3:0] C_LOAD = 4'(T_SEG - 1);

  logic [3:0] r_cnt;

  // Auto-reloads so back-to-back segments need no explicit restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= C_LOAD;
    end else if (restart || (r_cnt == 4'd0)) begin
      r_cnt <= C_LOAD;
    end else begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign seg_done = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/rtc_time_reader.sv
`default_nettype none
// ============================================================================
// Module : rtc_time_reader
// Brief  : RTC bus read master; sweeps sec/min/hour and publishes a coherent
//          BCD snapshot with a one-cycle time_valid pulse.
// Rev    : 1.0  initial release
// ============================================================================
module rtc_time_reader
  import rtc_defs_pkg::*;
#(
  parameter int unsigned T_SEG     = T_SEG_DEF,
  parameter logic [7:0]  ADDR_SEC  = RTC_ADDR_SEC,
  parameter logic [7:0]  ADDR_MIN  = RTC_ADDR_MIN,
  parameter logic [7:0]  ADDR_HOUR = RTC_ADDR_HOUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       write_busy,
  input  logic [7:0] rtc_bus_in,
  output logic [7:0] rtc_bus_out,
  output logic       rtc_bus_oe,
  output logic       rtc_cs_n,
  output logic       rtc_ad_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       time_valid,
  output logic       busy
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [1:0] r_idx;
  logic [1:0] w_next_idx;
  logic       r_pending;
  logic       r_abort;
  logic [7:0] r_shadow [0:2];
  logic       w_seg_done;
  logic       w_restart;
  logic       w_launch;
  logic       w_abort_now;
  logic       w_gap_end;
  bus_ctl_t   w_ctl;
  logic [7:0] w_addr;

  assign w_restart   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_launch    = (r_state == S_IDLE) && r_pending && enable && !write_busy;
  assign w_abort_now = r_abort || write_busy;
  assign w_gap_end   = (r_state == S_GAP) && w_seg_done;

  rtc_bus_seg_timer #(
    .T_SEG (T_SEG)
  ) u_seg_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (w_restart),
    .seg_done (w_seg_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    if (!enable) begin
      w_next_state = S_IDLE;
      w_next_idx   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            w_next_state = S_A_SU;
            w_next_idx   = 2'd0;
          end
        end
        S_A_SU, S_A_STB, S_A_HLD, S_R_SU, S_R_STB, S_R_HLD: begin
          if (w_seg_done) w_next_state = r_state + 4'd1;
        end
        S_GAP: begin
          // A setter request seen anywhere in this register drops the sweep here.
          if (w_seg_done) begin
            if (w_abort_now) begin
              w_next_state = S_IDLE;
              w_next_idx   = 2'd0;
            end else if (r_idx == 2'd2) begin
              w_next_state = S_DONE;
            end else begin
              w_next_state = S_A_SU;
              w_next_idx   = r_idx + 2'd1;
            end
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_idx   = 2'd0;
        end
      endcase
    end
  end

  // Bus pattern for the state being entered, registered below.
  always_comb begin
    w_ctl  = BUS_RELEASED;
    w_addr = 8'h00;
    case (w_next_state)
      S_A_SU, S_A_HLD: begin
        w_ctl.cs_n = 1'b0;
        w_ctl.oe   = 1'b1;
        w_addr     = reg_addr(w_next_idx, ADDR_SEC, ADDR_MIN, ADDR_HOUR);
      end
      S_A_STB: begin
        w_ctl.cs_n = 1'b0;
        w_ctl.oe   = 1'b1;
        w_ctl.ad_n = 1'b0;
        w_addr     = reg_addr(w_next_idx, ADDR_SEC, ADDR_MIN, ADDR_HOUR);
      end
      S_R_SU, S_R_HLD: begin
        w_ctl.cs_n = 1'b0;
      end
      S_R_STB: begin
        w_ctl.cs_n = 1'b0;
        w_ctl.rd_n = 1'b0;
      end
      default: begin
        w_ctl  = BUS_RELEASED;
        w_addr = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtc_bus_out <= 8'h00;
      rtc_bus_oe  <= 1'b0;
      rtc_cs_n    <= 1'b1;
      rtc_ad_n    <= 1'b1;
      rtc_rd_n    <= 1'b1;
      rtc_wr_n    <= 1'b1;
      sec         <= 8'h00;
      min         <= 8'h00;
      hour        <= 8'h00;
      time_valid  <= 1'b0;
      busy        <= 1'b0;
      r_pending   <= 1'b0;
      r_abort     <= 1'b0;
      for (int i = 0; i < 3; i++) r_shadow[i] <= 8'h00;
    end else begin
      rtc_bus_out <= w_addr;
      rtc_bus_oe  <= w_ctl.oe;
      rtc_cs_n    <= w_ctl.cs_n;
      rtc_ad_n    <= w_ctl.ad_n;
      rtc_rd_n    <= w_ctl.rd_n;
      rtc_wr_n    <= 1'b1;
      busy        <= (w_next_state != S_IDLE);
      time_valid  <= (w_next_state == S_DONE);

      if (w_next_state == S_DONE) begin
        sec  <= r_shadow[0];
        min  <= r_shadow[1];
        hour <= r_shadow[2];
      end

      if ((r_state == S_R_STB) && w_seg_done) r_shadow[r_idx] <= rtc_bus_in;

      if (start) begin
        r_pending <= 1'b1;
      end else if (w_gap_end && w_abort_now && enable) begin
        r_pending <= 1'b1;
      end else if (w_launch) begin
        r_pending <= 1'b0;
      end

      if (w_next_state == S_IDLE) begin
        r_abort <= 1'b0;
      end else if (write_busy && (r_state != S_IDLE)) begin
        r_abort <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
